crc_pkt_ctrl: RTL and testbench
===============================

Name: crc_pkt_ctrl

Overview:
Sequences the router's 8-bit CRC engine over byte-wide packets.
- Generate mode: forwards the payload and appends one CRC byte after the last payload byte.
- Check mode: strips the trailing CRC byte, compares it with the computed value and flags a mismatch on the last output byte.
- Sits between the router input port and the packet buffer, with valid/ready on both sides.

Parameters:
- INIT_VAL, 8'hFF, CRC register value at each start of packet.
- GEN_DEFAULT, 1'b1, mode used when mode_i is held constant (documentation only; mode_i always decides).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mode_i  in  1  1 = generate, 0 = check; sampled on the accepted SOP byte only
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid & in_ready
- in_data  in  8  input byte
- in_sop  in  1  first byte of packet
- in_eop  in  1  last byte of packet (may equal SOP)
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts
- out_data  out  8  output byte
- out_sop  out  1  first output byte
- out_eop  out  1  last output byte
- out_crc_err  out  1  check mode only; valid with out_eop; 1 = mismatch
- runt_err  out  1  one-cycle pulse: check-mode packet of length 1 was dropped

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, CRC register = INIT_VAL, hold register is empty. Reset mid-packet discards the packet; no partial EOP is emitted.
- CRC update: combinational step matching the team's crc8 engine (poly x^8+x^7+x^6+x^3+x^2+x+1, no reflection, no final XOR). Applied once per accepted payload byte.
- Output register: one stage. out_* stays stable while out_valid & !out_ready.
- in_ready = !out_valid | out_ready, except in GEN_APPEND, where in_ready = 0.
- FSM IDLE:
  - Bytes without in_sop are dropped (in_ready = 1).
  - On an accepted SOP, latch the mode and load CRC = step(INIT_VAL, byte).
  - Generate: emit the byte with out_sop. Go to GEN_DATA, or to GEN_APPEND if in_eop.
  - Check: if in_eop, drop the byte, pulse runt_err and stay in IDLE. Otherwise store the byte in the hold register with a pending SOP flag and go to CHK_DATA.
- FSM GEN_DATA:
  - Each accepted byte updates the CRC and is emitted.
  - in_eop moves to GEN_APPEND; that byte is emitted with out_eop = 0.
  - A byte with in_sop mid-packet is treated as payload; SOP is not re-evaluated.
- FSM GEN_APPEND:
  - Emit out_data = CRC with out_eop = 1 when the output register is free, then return to IDLE.
  - Latency is one cycle from the accepted EOP byte to the CRC byte, when unstalled.
- FSM CHK_DATA:
  - Accepted byte without in_eop: emit the hold byte (out_sop = pending flag), update the CRC with the new byte, store the new byte in hold.
  - Accepted byte with in_eop: this byte is the received CRC. Emit the hold byte with out_eop = 1 and out_crc_err = (CRC != in_data). Return to IDLE and reset the CRC to INIT_VAL.
- Back-to-back packets: an SOP is accepted in the cycle after GEN_APPEND/CHK_DATA returns to IDLE. There are no bubbles other than the appended CRC cycle.

Optional Feature:
- Macro CRC_PKT_STATS_EN.
- Defined: adds outputs pkt_cnt[15:0] and err_cnt[15:0].
  - pkt_cnt increments on each emitted out_eop.
  - err_cnt increments on each out_crc_err or runt_err.
  - Both counters saturate at 16'hFFFF and are cleared by rst or by the input stats_clr (1 bit). Clear wins over a simultaneous increment.
- Undefined: the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Package crc_pkt_pkg holds:
  - the FSM state enum (IDLE, GEN_DATA, GEN_APPEND, CHK_DATA);
  - constant CRC_W = 8;
  - function crc8_step(crc, data) implementing the engine equations.
- One sub-module is natural: crc_pkt_oreg, the single-stage output register with valid/ready and skid logic.
- The CRC itself stays inline via crc8_step; the sequential engine is not instantiated, to keep reset synchronous.

Test Plan:
- Generate, payload {0xFF} (SOP+EOP) -> out: 0xFF (sop), 0x00 (eop), crc_err = 0.
- Generate, payload {0x00} -> out: 0x00 (sop), 0xD2 (eop).
- Check, input {0x00, 0xD2} -> out: 0x00 with sop+eop, out_crc_err = 0. Input {0x00, 0xD3} -> same byte, out_crc_err = 1.
- Check, single byte with SOP+EOP -> nothing emitted, runt_err pulses 1 cycle; the next packet is processed normally.
- Random out_ready stalls on a 64-byte generate packet followed by the looped-back check packet -> output data stable under stall, no loss or duplication, crc_err = 0.
- Assert rst for 1 cycle mid-packet in each mode -> outputs 0 the next cycle; a following {0xFF} generate packet yields trailing 0x00.

Source files
------------

// File: rtl/crc_pkt_pkg.sv
// Shared types and the combinational crc8 step for the packet CRC controller.
package crc_pkt_pkg;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'hCF;

  typedef enum logic [1:0] {
    IDLE,
    GEN_DATA,
    GEN_APPEND,
    CHK_DATA
  } state_e;

  // MSB-first, no reflection, no final XOR: x^8+x^7+x^6+x^3+x^2+x+1.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic [CRC_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < CRC_W; i++) begin
      c = c[CRC_W-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_pkt_oreg.sv
// Single-stage output register: holds its beat while the consumer stalls.
module crc_pkt_oreg
  import crc_pkt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [CRC_W-1:0] data_i,
  input  logic             sop_i,
  input  logic             eop_i,
  input  logic             err_i,
  output logic             free_o,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CRC_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_crc_err
);

  logic             valid_q, valid_d;
  logic [CRC_W-1:0] data_q, data_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             err_q, err_d;

  assign free_o = !valid_q | out_ready;

  // The producer only pushes when free_o is high, so a push never overwrites a stalled beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    err_d   = err_q;
    if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sop_d   = sop_i;
      eop_d   = eop_i;
      err_d   = err_i;
    end else if (out_ready) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_sop     = sop_q;
  assign out_eop     = eop_q;
  assign out_crc_err = err_q;

endmodule

// File: rtl/crc_pkt_ctrl.sv
// Packet CRC sequencer: appends (generate) or strips and verifies (check) a trailing crc8 byte.
// Optional statistics counters are enabled by defining CRC_PKT_STATS_EN.
module crc_pkt_ctrl
  import crc_pkt_pkg::*;
#(
  parameter logic [CRC_W-1:0] INIT_VAL    = 8'hFF,
  parameter logic             GEN_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CRC_W-1:0] in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CRC_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_crc_err,
  output logic             runt_err
`ifdef CRC_PKT_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      err_cnt
`endif
);

  // GEN_DEFAULT is informational only; mode_i always selects the mode.
  logic unused_gen_default;
  assign unused_gen_default = GEN_DEFAULT;

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] hold_q, hold_d;
  logic             hold_sop_q, hold_sop_d;
  logic             runt_q, runt_d;

  logic             free;
  logic             push;
  logic [CRC_W-1:0] push_data;
  logic             push_sop, push_eop, push_err;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    hold_d     = hold_q;
    hold_sop_d = hold_sop_q;
    runt_d     = 1'b0;
    in_ready   = free;
    push       = 1'b0;
    push_data  = in_data;
    push_sop   = 1'b0;
    push_eop   = 1'b0;
    push_err   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = free | !in_sop;
        if (in_valid && in_ready && in_sop) begin
          crc_d = crc8_step(INIT_VAL, in_data);
          if (mode_i) begin
            push     = 1'b1;
            push_sop = 1'b1;
            state_d  = in_eop ? GEN_APPEND : GEN_DATA;
          end else if (in_eop) begin
            runt_d = 1'b1;
            crc_d  = INIT_VAL;
          end else begin
            hold_d     = in_data;
            hold_sop_d = 1'b1;
            state_d    = CHK_DATA;
          end
        end
      end
      GEN_DATA: begin
        if (in_valid && in_ready) begin
          crc_d = crc8_step(crc_q, in_data);
          push  = 1'b1;
          if (in_eop) state_d = GEN_APPEND;
        end
      end
      GEN_APPEND: begin
        in_ready = 1'b0;
        if (free) begin
          push      = 1'b1;
          push_data = crc_q;
          push_eop  = 1'b1;
          crc_d     = INIT_VAL;
          state_d   = IDLE;
        end
      end
      CHK_DATA: begin
        // The byte in hold goes out one beat late so the EOP byte (the received CRC) can be stripped.
        if (in_valid && in_ready) begin
          push       = 1'b1;
          push_data  = hold_q;
          push_sop   = hold_sop_q;
          hold_sop_d = 1'b0;
          if (in_eop) begin
            push_eop = 1'b1;
            push_err = (crc_q != in_data);
            crc_d    = INIT_VAL;
            state_d  = IDLE;
          end else begin
            crc_d  = crc8_step(crc_q, in_data);
            hold_d = in_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= INIT_VAL;
      hold_q     <= '0;
      hold_sop_q <= 1'b0;
      runt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      hold_q     <= hold_d;
      hold_sop_q <= hold_sop_d;
      runt_q     <= runt_d;
    end
  end

  assign runt_err = runt_q;

  crc_pkt_oreg u_oreg (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .data_i      (push_data),
    .sop_i       (push_sop),
    .eop_i       (push_eop),
    .err_i       (push_err),
    .free_o      (free),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_crc_err (out_crc_err)
  );

`ifdef CRC_PKT_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        eop_fire;

  assign eop_fire = out_valid & out_ready & out_eop;

  // Saturating counters; clear takes priority over a same-cycle increment.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (stats_clr) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (eop_fire && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (((eop_fire && out_crc_err) || runt_q) && err_cnt_q != 16'hFFFF)
        err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_pkt_ctrl.sv
// Directed bench for crc_pkt_ctrl: table-driven packets plus reset, runt and stall sequences.
module tb_crc_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_i = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_sop, out_eop, out_crc_err, runt_err;
`ifdef CRC_PKT_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] pkt_cnt, err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc_pkt_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode_i),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_crc_err (out_crc_err),
    .runt_err    (runt_err)
`ifdef CRC_PKT_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .pkt_cnt     (pkt_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  typedef struct {
    logic            mode;
    int              n_in;
    logic [2:0][7:0] in_b;
    int              n_out;
    logic [2:0][7:0] out_b;
    logic            err;
  } vec_t;

  beat_t got[$];
  int    runt_cycles = 0;
  logic  stall_en = 1'b0;

  // Bit-serial LFSR reference for the crc8 polynomial.
  function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'hCF;
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic m, input int ni, input logic [7:0] i0, i1, i2,
                              input int no, input logic [7:0] o0, o1, o2, input logic e);
    vec_t v;
    v.mode = m;   v.n_in = ni;  v.n_out = no; v.err = e;
    v.in_b[0] = i0; v.in_b[1] = i1; v.in_b[2] = i2;
    v.out_b[0] = o0; v.out_b[1] = o1; v.out_b[2] = o2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one byte and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic m, input logic [7:0] d, input logic s, input logic e);
    logic acc;
    int   n;
    mode_i = m; in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop, out_crc_err});
      if (runt_err) runt_cycles++;
    end
  end

  // Output must not change while stalled.
  logic       prev_stall = 1'b0;
  logic [11:0] prev_out = '0;
  always @(negedge clk) begin
    if (!rst && prev_stall)
      checkOutput("stall_stable", {20'd0, out_valid, out_data, out_sop, out_eop, out_crc_err},
                  {20'd0, prev_out});
    prev_out   = {out_valid, out_data, out_sop, out_eop, out_crc_err};
    prev_stall = !rst && out_valid && !out_ready;
  end

  always @(posedge clk) begin
    #1;
    out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkPacket(input string name, input int n, input logic [7:0] exp_d [$],
                             input logic exp_err);
    checkOutput({name, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      checkOutput({name, "_data"}, got[i].d, exp_d[i]);
      checkOutput({name, "_sop"}, got[i].sop, (i == 0));
      checkOutput({name, "_eop"}, got[i].eop, (i == n - 1));
      checkOutput({name, "_err"}, got[i].err, (i == n - 1) ? exp_err : 1'b0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] payload[64];
    logic [7:0] loop_b[$];
    logic [7:0] crc;

    vecs[0] = mk(1'b1, 1, 8'hFF, 8'h00, 8'h00, 2, 8'hFF, 8'h00, 8'h00, 1'b0);
    vecs[1] = mk(1'b1, 1, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'hD2, 8'h00, 1'b0);
    vecs[2] = mk(1'b0, 2, 8'h00, 8'hD2, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[3] = mk(1'b0, 2, 8'h00, 8'hD3, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b1);
    vecs[4] = mk(1'b1, 2, 8'h00, 8'hFF, 8'h00, 3, 8'h00, 8'hFF, 8'h9B, 1'b0);
    vecs[5] = mk(1'b0, 3, 8'h00, 8'hFF, 8'h9B, 2, 8'h00, 8'hFF, 8'h00, 1'b0);

    idle(3);
    rst = 1'b0;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_flags", {out_sop, out_eop, out_crc_err, runt_err}, 0);
    checkOutput("reset_out_data", out_data, 0);

    for (int v = 0; v < 6; v++) begin
      got.delete();
      for (int i = 0; i < vecs[v].n_in; i++)
        applyStimulus(vecs[v].mode, vecs[v].in_b[i], (i == 0), (i == vecs[v].n_in - 1));
      idle(4);
      exp_q.delete();
      for (int i = 0; i < vecs[v].n_out; i++) exp_q.push_back(vecs[v].out_b[i]);
      checkPacket($sformatf("vec%0d", v), vecs[v].n_out, exp_q, vecs[v].err);
    end

    // Runt check packet, then a normal generate packet.
    got.delete();
    runt_cycles = 0;
    applyStimulus(1'b0, 8'h5A, 1'b1, 1'b1);
    idle(3);
    checkOutput("runt_pulse_cycles", runt_cycles, 1);
    checkOutput("runt_no_output", got.size(), 0);
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
    idle(4);
    exp_q = '{8'hFF, 8'h00};
    checkPacket("after_runt", 2, exp_q, 1'b0);

    // Mid-packet reset in each mode, then a clean {0xFF} generate packet.
    for (int m = 0; m < 2; m++) begin
      got.delete();
      applyStimulus(1'(m), 8'h11, 1'b1, 1'b0);
      applyStimulus(1'(m), 8'h22, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput($sformatf("midrst%0d_out", m),
                  {out_valid, out_data, out_sop, out_eop, out_crc_err, runt_err}, 0);
      idle(2);
      got.delete();
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
      idle(4);
      exp_q = '{8'hFF, 8'h00};
      checkPacket($sformatf("midrst%0d_next", m), 2, exp_q, 1'b0);
    end

    // 64-byte generate packet under random stalls, then loop it back in check mode.
    got.delete();
    crc = 8'hFF;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      payload[i] = 8'((i * 37 + 5) & 8'hFF);
      crc = ref_crc(crc, payload[i]);
      exp_q.push_back(payload[i]);
    end
    exp_q.push_back(crc);
    stall_en = 1'b1;
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, payload[i], (i == 0), (i == 63));
    stall_en = 1'b0;
    idle(6);
    checkPacket("stall_gen", 65, exp_q, 1'b0);

    loop_b.delete();
    foreach (got[i]) loop_b.push_back(got[i].d);
    got.delete();
    stall_en = 1'b1;
    for (int i = 0; i < loop_b.size(); i++)
      applyStimulus(1'b0, loop_b[i], (i == 0), (i == loop_b.size() - 1));
    stall_en = 1'b0;
    idle(6);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(payload[i]);
    checkPacket("stall_chk", 64, exp_q, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
